// File: rtl/placement_cost_eval.sv
// Edge-list wirelength evaluator: fetches both endpoint positions per edge and
// accumulates Manhattan and 1-hop cost. Define PLACEMENT_MAXLEN_EN to track max_len.
module placement_cost_eval #(
  parameter int N_EDGE  = 71,
  parameter int EDGE_AW = 9,
  parameter int POS_AW  = 7,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 edge_re,
  output logic [EDGE_AW-1:0]   edge_addr,
  input  logic [DW-1:0]        edge_a,
  input  logic [DW-1:0]        edge_b,
  output logic                 pos_re,
  output logic [POS_AW-1:0]    pos_addr,
  input  logic signed [DW-1:0] pos_x,
  input  logic signed [DW-1:0] pos_y,
  output logic signed [DW-1:0] sum,
  output logic signed [DW-1:0] sum_1hop,
  output logic [DW-1:0]        max_len,
  output logic                 unplaced_err
);

  localparam logic [EDGE_AW:0] N_EDGE_C = (EDGE_AW+1)'(N_EDGE);

  typedef enum logic [3:0] {
    IDLE, E_RD, E_WT, A_RD, A_WT, B_RD, B_WT, B_CAP, DIFF, ACC, DONE
  } state_t;

  function automatic logic [DW-1:0] abs_diff(input logic signed [DW-1:0] a,
                                             input logic signed [DW-1:0] b);
    logic [DW-1:0] d;
    d = a - b;
    return d[DW-1] ? -d : d;
  endfunction

  function automatic logic [DW-1:0] ceil_half(input logic [DW-1:0] v);
    return (v >> 1) + {{(DW-1){1'b0}}, v[0]};
  endfunction

  function automatic logic is_unplaced(input logic signed [DW-1:0] v);
    return v == '1;
  endfunction

  state_t                state_q;
  logic [EDGE_AW:0]      i_q, i_d;
  logic                  busy_q, done_q, edge_re_q, pos_re_q, err_q;
  logic [EDGE_AW-1:0]    edge_addr_q;
  logic [POS_AW-1:0]     pos_addr_q, b_q;
  logic signed [DW-1:0]  sum_q, hop_q;
  logic signed [DW-1:0]  xa_q, ya_q, xb_q, yb_q;
  logic [DW-1:0]         dx_q, dy_q, len_d, hop_d;
  logic                  unplaced_d;
  logic                  unused_hi;

  assign i_d        = i_q + 1'b1;
  assign len_d      = dx_q + dy_q;
  assign hop_d      = ceil_half(dx_q) + ceil_half(dy_q) - DW'(1);
  assign unplaced_d = is_unplaced(xa_q) | is_unplaced(ya_q) |
                      is_unplaced(xb_q) | is_unplaced(yb_q);
  assign unused_hi  = ^{edge_a[DW-1:POS_AW], edge_b[DW-1:POS_AW]};

  // edge_a is used straight from the ROM in A_RD so a 2-cycle ROM still works
  assign pos_addr = (state_q == A_RD) ? edge_a[POS_AW-1:0] : pos_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      edge_re_q   <= 1'b0;
      edge_addr_q <= '0;
      pos_re_q    <= 1'b0;
      pos_addr_q  <= '0;
      sum_q       <= '0;
      hop_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      edge_re_q <= 1'b0;
      pos_re_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sum_q       <= '0;
          hop_q       <= '0;
          err_q       <= 1'b0;
          i_q         <= '0;
          edge_addr_q <= '0;
          if (N_EDGE_C == '0) begin
            state_q <= DONE;
          end else begin
            state_q   <= E_RD;
            busy_q    <= 1'b1;
            edge_re_q <= 1'b1;
          end
        end
        E_RD:  state_q <= E_WT;
        E_WT: begin
          state_q  <= A_RD;
          pos_re_q <= 1'b1;
        end
        A_RD: begin
          state_q    <= A_WT;
          pos_addr_q <= edge_a[POS_AW-1:0];
        end
        A_WT: begin
          state_q    <= B_RD;
          pos_re_q   <= 1'b1;
          pos_addr_q <= b_q;
        end
        B_RD:  state_q <= B_WT;
        B_WT:  state_q <= B_CAP;
        B_CAP: state_q <= DIFF;
        DIFF:  state_q <= ACC;
        ACC: begin
          if (unplaced_d) begin
            err_q <= 1'b1;
          end else begin
            sum_q <= sum_q + $signed(len_d - DW'(1));
            hop_q <= hop_q + $signed(hop_d);
          end
          i_q <= i_d;
          if (i_d == N_EDGE_C) begin
            state_q <= DONE;
          end else begin
            state_q     <= E_RD;
            edge_re_q   <= 1'b1;
            edge_addr_q <= i_d[EDGE_AW-1:0];
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // datapath capture: b id, endpoint A, endpoint B, then |dx|,|dy|
  always_ff @(posedge clk) begin
    case (state_q)
      A_RD: b_q <= edge_b[POS_AW-1:0];
      B_RD: begin
        xa_q <= pos_x;
        ya_q <= pos_y;
      end
      B_CAP: begin
        xb_q <= pos_x;
        yb_q <= pos_y;
      end
      DIFF: begin
        dx_q <= abs_diff(xa_q, xb_q);
        dy_q <= abs_diff(ya_q, yb_q);
      end
      default: ;
    endcase
  end

`ifdef PLACEMENT_MAXLEN_EN
  logic [DW-1:0] max_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                            max_q <= '0;
    else if (state_q == IDLE && start)                     max_q <= '0;
    else if (state_q == ACC && !unplaced_d && len_d > max_q) max_q <= len_d;
  end

  assign max_len = max_q;
`else
  assign max_len = '0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign edge_re      = edge_re_q;
  assign edge_addr    = edge_addr_q;
  assign pos_re       = pos_re_q;
  assign sum          = sum_q;
  assign sum_1hop     = hop_q;
  assign unplaced_err = err_q;

endmodule

// File: tb/tb_placement_cost_eval.sv
// Directed bench for placement_cost_eval: 1-edge vector table, 2-edge sequences
// (ignored start, back-to-back, mid-run reset) and a 71-edge dataset.
module tb_placement_cost_eval;

`ifdef PLACEMENT_MAXLEN_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] edgeA [0:511];
  logic [31:0] edgeB [0:511];
  logic signed [31:0] posx [0:127];
  logic signed [31:0] posy [0:127];

  logic st1, bz1, dn1, er1, pr1, ue1;
  logic st2, bz2, dn2, er2, pr2, ue2;
  logic st3, bz3, dn3, er3, pr3, ue3;
  logic [8:0] ad1, ad2, ad3;
  logic [6:0] pa1, pa2, pa3;
  logic [31:0] ea1, eb1, ea2, eb2, ea3, eb3, mx1, mx2, mx3;
  logic signed [31:0] px1, py1, px2, py2, px3, py3;
  logic signed [31:0] sm1, hp1, sm2, hp2, sm3, hp3;

  placement_cost_eval #(.N_EDGE(1)) u1 (
    .clk(clk), .reset(reset), .start(st1), .busy(bz1), .done(dn1),
    .edge_re(er1), .edge_addr(ad1), .edge_a(ea1), .edge_b(eb1),
    .pos_re(pr1), .pos_addr(pa1), .pos_x(px1), .pos_y(py1),
    .sum(sm1), .sum_1hop(hp1), .max_len(mx1), .unplaced_err(ue1));

  placement_cost_eval #(.N_EDGE(2)) u2 (
    .clk(clk), .reset(reset), .start(st2), .busy(bz2), .done(dn2),
    .edge_re(er2), .edge_addr(ad2), .edge_a(ea2), .edge_b(eb2),
    .pos_re(pr2), .pos_addr(pa2), .pos_x(px2), .pos_y(py2),
    .sum(sm2), .sum_1hop(hp2), .max_len(mx2), .unplaced_err(ue2));

  placement_cost_eval #(.N_EDGE(71)) u3 (
    .clk(clk), .reset(reset), .start(st3), .busy(bz3), .done(dn3),
    .edge_re(er3), .edge_addr(ad3), .edge_a(ea3), .edge_b(eb3),
    .pos_re(pr3), .pos_addr(pa3), .pos_x(px3), .pos_y(py3),
    .sum(sm3), .sum_1hop(hp3), .max_len(mx3), .unplaced_err(ue3));

  // 1-cycle registered ROM/RAM models, one read port set per instance
  always @(posedge clk) begin
    if (er1) begin ea1 <= edgeA[ad1]; eb1 <= edgeB[ad1]; end
    if (pr1) begin px1 <= posx[pa1];  py1 <= posy[pa1];  end
    if (er2) begin ea2 <= edgeA[ad2]; eb2 <= edgeB[ad2]; end
    if (pr2) begin px2 <= posx[pa2];  py2 <= posy[pa2];  end
    if (er3) begin ea3 <= edgeA[ad3]; eb3 <= edgeB[ad3]; end
    if (pr3) begin px3 <= posx[pa3];  py3 <= posy[pa3];  end
  end

  int checks = 0;
  int errors = 0;
  int er_cnt, pr_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      1: st1 = v;
      2: st2 = v;
      default: st3 = v;
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      1: return dn1;
      2: return dn2;
      default: return dn3;
    endcase
  endfunction

  task automatic pulse(input int sel);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
  endtask

  // Start a run, optionally re-pulse start so it is sampled at edge inj, and
  // check the cycle (edges after the start edge) at which done is seen.
  task automatic run(input int sel, input int exp_cyc, input int inj,
                     input bit chk_clr, input string nm);
    int c;
    bit seen;
    seen = 1'b0;
    c = 0;
    pulse(sel);
    if (sel == 3) begin er_cnt += int'(er3); pr_cnt += int'(pr3); end
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      set_start(sel, (k == inj - 1));
      if (sel == 3) begin er_cnt += int'(er3); pr_cnt += int'(pr3); end
      if (chk_clr && k == 1) chk({nm, " sum_cleared"}, sm2, 32'd0);
      if (done_of(sel)) begin
        c = k;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, " done_timeout"}, 32'd0, 32'd1);
    else       chk({nm, " done_cycle"}, c, exp_cyc);
  endtask

  task automatic chk_idle2(input string nm);
    chk({nm, " busy"}, 32'(bz2), 32'd0);
    chk({nm, " done"}, 32'(dn2), 32'd0);
    chk({nm, " edge_re"}, 32'(er2), 32'd0);
    chk({nm, " pos_re"}, 32'(pr2), 32'd0);
    chk({nm, " edge_addr"}, 32'(ad2), 32'd0);
    chk({nm, " pos_addr"}, 32'(pa2), 32'd0);
    chk({nm, " sum"}, sm2, 32'd0);
    chk({nm, " sum_1hop"}, hp2, 32'd0);
    chk({nm, " max_len"}, mx2, 32'd0);
    chk({nm, " unplaced"}, 32'(ue2), 32'd0);
  endtask

  task automatic chk_res2(input string nm);
    chk({nm, " sum"}, sm2, 32'd4);
    chk({nm, " sum_1hop"}, hp2, 32'd2);
    chk({nm, " max_len"}, mx2, MAXEN ? 32'd5 : 32'd0);
    chk({nm, " unplaced"}, 32'(ue2), 32'd0);
  endtask

  typedef struct {
    int a, b;
    int xa, ya, xb, yb;
    int esum, ehop, emax;
    bit eerr;
  } vec_t;

  vec_t vt [6];

  initial begin
    longint s, h, m, dx, dy;
    int a, b;

    vt[0] = '{a:0,   b:1, xa:0,  ya:0,  xb:3,  yb:2,  esum:4,  ehop:2,  emax:5,  eerr:0};
    vt[1] = '{a:0,   b:1, xa:0,  ya:0,  xb:-1, yb:2,  esum:0,  ehop:0,  emax:0,  eerr:1};
    vt[2] = '{a:4,   b:4, xa:2,  ya:2,  xb:2,  yb:2,  esum:-1, ehop:-1, emax:0,  eerr:0};
    vt[3] = '{a:131, b:5, xa:1,  ya:1,  xb:4,  yb:1,  esum:2,  ehop:1,  emax:3,  eerr:0};
    vt[4] = '{a:6,   b:7, xa:-5, ya:4,  xb:2,  yb:-3, esum:13, ehop:7,  emax:14, eerr:0};
    vt[5] = '{a:8,   b:9, xa:5,  ya:-1, xb:0,  yb:0,  esum:0,  ehop:0,  emax:0,  eerr:1};

    reset = 1'b0;
    st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
    er_cnt = 0; pr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle2("reset");
    chk("reset busy3", 32'(bz3), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // single-edge vector table
    for (int r = 0; r < 6; r++) begin
      edgeA[0] = vt[r].a;
      edgeB[0] = vt[r].b;
      posx[vt[r].a % 128] = vt[r].xa;
      posy[vt[r].a % 128] = vt[r].ya;
      posx[vt[r].b % 128] = vt[r].xb;
      posy[vt[r].b % 128] = vt[r].yb;
      run(1, 10, -1, 1'b0, $sformatf("vec%0d", r));
      chk($sformatf("vec%0d sum", r), sm1, vt[r].esum);
      chk($sformatf("vec%0d sum_1hop", r), hp1, vt[r].ehop);
      chk($sformatf("vec%0d max_len", r), mx1, MAXEN ? vt[r].emax : 0);
      chk($sformatf("vec%0d unplaced", r), 32'(ue1), 32'(vt[r].eerr));
      chk($sformatf("vec%0d busy_low", r), 32'(bz1), 32'd0);
    end

    // two-edge sequences
    edgeA[0] = 0; edgeB[0] = 1;
    edgeA[1] = 1; edgeB[1] = 2;
    posx[0] = 0; posy[0] = 0;
    posx[1] = 3; posy[1] = 2;
    posx[2] = 3; posy[2] = 3;

    run(2, 19, -1, 1'b0, "two_edge");
    chk_res2("two_edge");
    @(posedge clk);
    #1;
    chk("two_edge done_one_cycle", 32'(dn2), 32'd0);

    run(2, 19, 5, 1'b0, "ignore_start");
    chk_res2("ignore_start");
    run(2, 19, -1, 1'b1, "back_to_back");
    chk_res2("back_to_back");

    pulse(2);
    repeat (7) @(posedge clk);
    #1;
    chk("midrst busy_before", 32'(bz2), 32'd1);
    reset = 1'b0;
    #1;
    chk_idle2("midrst");
    @(negedge clk);
    reset = 1'b1;
    run(2, 19, -1, 1'b0, "after_rst");
    chk_res2("after_rst");

    // 71-edge dataset with an independent reference model
    for (int k = 0; k < 128; k++) begin
      posx[k] = (k * 13) % 40;
      posy[k] = (k * 29) % 37;
    end
    s = 0; h = 0; m = 0;
    for (int i = 0; i < 71; i++) begin
      a = (i * 5) % 100;
      b = (i * i + 3 * i + 1) % 100;
      edgeA[i] = a;
      edgeB[i] = b;
      dx = (posx[a] > posx[b]) ? longint'(posx[a] - posx[b]) : longint'(posx[b] - posx[a]);
      dy = (posy[a] > posy[b]) ? longint'(posy[a] - posy[b]) : longint'(posy[b] - posy[a]);
      s += dx + dy - 1;
      h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
      if (dx + dy > m) m = dx + dy;
    end
    er_cnt = 0;
    pr_cnt = 0;
    run(3, 640, -1, 1'b0, "poly5");
    chk("poly5 sum", sm3, s[31:0]);
    chk("poly5 sum_1hop", hp3, h[31:0]);
    chk("poly5 max_len", mx3, MAXEN ? m[31:0] : 32'd0);
    chk("poly5 unplaced", 32'(ue3), 32'd0);
    chk("poly5 edge_re_count", er_cnt, 32'd71);
    chk("poly5 pos_re_count", pr_cnt, 32'd142);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
